// File: rtl/f_fetch_pkg.sv
// Shared definitions for the F-stage fetch sequencer: reset PC, FSM encoding, NOP word.
package f_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StWaitBuf = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/f_fetch_buf.sv
// Single-entry F/D instruction buffer; a load takes priority over a consume on the same edge.
// F_ALIGN_CHECK_EN adds the address-error flag carried with the entry.
module f_fetch_buf
    import f_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        consume,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
`ifdef F_ALIGN_CHECK_EN
    input  logic        load_adel,
    output logic        adel,
`endif
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            pc    <= RESET_PC;
            instr <= NOP_WORD;
`ifdef F_ALIGN_CHECK_EN
            adel  <= 1'b0;
`endif
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
`ifdef F_ALIGN_CHECK_EN
            adel  <= load_adel;
`endif
        end else if (consume) begin
            valid <= 1'b0;
`ifdef F_ALIGN_CHECK_EN
            adel  <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/f_fetch_ctrl.sv
// F-stage fetch sequencer: owns the fetch PC, drives the imem req/ack handshake and applies
// D-stage redirects with delay-slot semantics. Optional F_ALIGN_CHECK_EN adds f_adel.
module f_fetch_ctrl
    import f_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_stall,
    input  logic        d_redirect_valid,
    input  logic [31:0] d_redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
`ifdef F_ALIGN_CHECK_EN
    output logic        f_adel,
`endif
    output logic        f_valid,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr
);

    fetch_state_e state_q;
    logic [31:0]  next_pc_q, req_addr_q, skid_pc_q, skid_instr_q;
    logic         req_q;

    logic         consume, buf_free, redirect, resp, issue, issue_req, buf_load;
    logic [31:0]  issue_addr, next_pc_d, resp_instr, buf_load_pc, buf_load_instr;
`ifdef F_ALIGN_CHECK_EN
    logic         skid_adel_q, resp_adel, buf_load_adel;
`endif

    always_comb begin
        consume  = f_valid & ~d_stall;
        buf_free = ~f_valid | consume;
        redirect = d_redirect_valid & ~d_stall;
`ifdef F_ALIGN_CHECK_EN
        // A misaligned entry makes no memory request; it completes on its own as a flagged nop.
        resp       = (state_q == StReq) & (req_q ? im_ack : 1'b1);
        resp_instr = req_q ? im_rdata : NOP_WORD;
        resp_adel  = ~req_q;
`else
        resp       = (state_q == StReq) & im_ack;
        resp_instr = im_rdata;
`endif

        unique case (state_q)
            StIdle:    issue = 1'b1;
            StReq:     issue = resp & buf_free;
            StWaitBuf: issue = consume;
            default:   issue = 1'b0;
        endcase

        // An ack coinciding with a redirect issues the target straight away.
        issue_addr = (resp & redirect) ? d_redirect_pc : next_pc_q;
`ifdef F_ALIGN_CHECK_EN
        issue_req  = (issue_addr[1:0] == 2'b00);
`else
        issue_req  = 1'b1;
`endif

        if (issue) begin
            if (redirect) begin
                next_pc_d = resp ? d_redirect_pc + 32'd4 : d_redirect_pc;
            end else begin
                next_pc_d = next_pc_q + 32'd4;
            end
        end else begin
            next_pc_d = redirect ? d_redirect_pc : next_pc_q;
        end

        buf_load       = (resp & buf_free) | ((state_q == StWaitBuf) & consume);
        buf_load_pc    = (state_q == StWaitBuf) ? skid_pc_q : req_addr_q;
        buf_load_instr = (state_q == StWaitBuf) ? skid_instr_q : resp_instr;
`ifdef F_ALIGN_CHECK_EN
        buf_load_adel  = (state_q == StWaitBuf) ? skid_adel_q : resp_adel;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            next_pc_q    <= RESET_PC;
            req_addr_q   <= RESET_PC;
            req_q        <= 1'b0;
            skid_pc_q    <= RESET_PC;
            skid_instr_q <= NOP_WORD;
`ifdef F_ALIGN_CHECK_EN
            skid_adel_q  <= 1'b0;
`endif
        end else begin
            next_pc_q <= next_pc_d;
            if (issue) begin
                req_addr_q <= issue_addr;
                req_q      <= issue_req;
            end
            unique case (state_q)
                StIdle: state_q <= StReq;
                StReq: begin
                    // Response arrives while D still holds the buffer: park it until consumed.
                    if (resp && !buf_free) begin
                        state_q      <= StWaitBuf;
                        req_q        <= 1'b0;
                        skid_pc_q    <= req_addr_q;
                        skid_instr_q <= resp_instr;
`ifdef F_ALIGN_CHECK_EN
                        skid_adel_q  <= resp_adel;
`endif
                    end
                end
                StWaitBuf: begin
                    if (consume) begin
                        state_q <= StReq;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign im_req  = req_q;
    assign im_addr = req_addr_q;

    f_fetch_buf #(
        .RESET_PC (RESET_PC)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .consume    (consume),
        .load_pc    (buf_load_pc),
        .load_instr (buf_load_instr),
`ifdef F_ALIGN_CHECK_EN
        .load_adel  (buf_load_adel),
        .adel       (f_adel),
`endif
        .valid      (f_valid),
        .pc         (f_pc),
        .instr      (f_instr)
    );

endmodule

// File: doc/f_fetch_ctrl.md
Name: f_fetch_ctrl

Overview:
- F-stage fetch sequencer for the MIPS 5-stage pipeline.
- Owns the fetch PC and issues requests to instruction memory over a req/ack handshake.
- Buffers one fetched instruction for the F/D register and applies D-stage redirects (taken branch, jump, jr) with MIPS delay-slot semantics.
- Sits between the D-stage next-PC logic and instruction memory; replaces the free-running F PC register.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- d_stall  in  1  hazard unit: D cannot accept a new instruction this cycle
- d_redirect_valid  in  1  one-cycle pulse: instruction in D is a taken branch/jump/jr
- d_redirect_pc  in  32  redirect target, valid with d_redirect_valid
- im_req  out  1  instruction-memory request
- im_addr  out  32  request address; stable while im_req=1 and im_ack=0
- im_ack  in  1  request complete this cycle; im_rdata valid
- im_rdata  in  32  fetched instruction word
- f_valid  out  1  f_instr/f_pc hold a valid instruction for D
- f_pc  out  32  PC of buffered instruction
- f_instr  out  32  buffered instruction word

Behaviour:
- Reset (reset=0, async): state IDLE; im_req=0; im_addr=RESET_PC; next_pc=RESET_PC; f_valid=0; f_pc=RESET_PC; f_instr=0.
- Consume: D takes the buffer on a rising edge where f_valid=1 and d_stall=0.
- States:
  - IDLE: first edge after reset release goes to REQ.
  - REQ: im_req=1, im_addr=req_addr.
  - WAIT_BUF: response captured, buffer full, D stalled.
- REQ is entered with req_addr<=next_pc and next_pc<=next_pc+4 when the buffer is empty or is consumed this cycle.
- im_ack may arrive in the first REQ cycle (zero-wait) or any later cycle.
- On ack edge:
  - f_instr<=im_rdata, f_pc<=req_addr, f_valid<=1.
  - If the buffer is free (empty or consumed this edge), issue the next request in the same edge (back-to-back, 1 instr/cycle with zero-wait memory); else go to WAIT_BUF.
- WAIT_BUF: im_req=0. On consume, go to REQ with the next address. f_* held stable while stalled.
- Consume with no ack pending: f_valid<=0.
- Redirect:
  - Sampled only when d_stall=0; ignored if d_stall=1, since D must re-present it.
  - The delay slot (branch_pc+4) is always already issued when the branch sits in D.
  - So redirect sets next_pc<=d_redirect_pc; the in-flight or buffered delay slot is delivered normally.
  - Redirect on the same edge as a request issue: that issue uses the already-advanced address (the delay slot or later-by-design). next_pc takes the target, not +4.
  - Redirect and ack on the same edge: the target wins over sequential +4.
- Address arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0.
- Reset asserted mid-request: im_req drops immediately; the pending ack is discarded; restart at RESET_PC.

Optional Feature:
- F_ALIGN_CHECK_EN defined: output f_adel (1 bit).
  - If the address to be issued has bits[1:0]!=0, no memory request is made.
  - Instead the buffer is loaded next edge with f_valid=1, f_instr=0 (nop), f_pc=address, f_adel=1.
  - f_adel clears when that entry is consumed; reset value 0.
- Undefined: no f_adel port; addresses are issued unchecked.

Decomposition:
- Shared package f_fetch_pkg: RESET_PC default, state encoding (IDLE, REQ, WAIT_BUF), NOP word 32'h0.
- One natural sub-module f_fetch_buf: the single-entry instruction/PC buffer with load/consume/valid logic.
- The FSM and next_pc logic stay in the top.

Test Plan:
- Reset and first fetch: hold reset=0 for 3 cycles, release, im_ack tied 1 → im_req first asserts with im_addr=0x3000 one edge after release; f_valid=1, f_pc=0x3000 the next edge.
- Sequential with 2-cycle ack latency → im_addr sequence 0x3000, 0x3004, 0x3008; each address held stable until ack; f_pc follows in order.
- Stall: buffer holds 0x3004, d_stall=1 for 3 cycles → im_req=0 after the pending ack; f_pc=0x3004 held; resumes at 0x3008 (and 0x300C) after d_stall=0.
- Branch: redirect pulse to 0x3100 while branch at 0x3008 is in D → fetched PCs 0x3008, 0x300C (delay slot), 0x3100, 0x3104.
- Redirect on the same edge as the delay-slot ack → next im_addr=0x3100, never 0x3010.
- Reset mid-fetch (im_req=1, no ack) → im_req=0 immediately; after release, the fetch restarts at 0x3000. With F_ALIGN_CHECK_EN, redirect to 0x3102 → f_adel=1, f_instr=0, f_pc=0x3102, no im_req for 0x3102.
